// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic, used by both the write-side
// and read-side pointer controllers.
package async_fifo_pkg;

    localparam int PTR_WIDTH_DEF = 8;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended inputs convert correctly because the unused upper bits stay zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_ctrl_if.sv
// Write-side pointer bus: producer request, full/read-pointer feedback, memory
// write port and the pointer/level/flag outputs.
interface wptr_ctrl_if
    import async_fifo_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEF
);

    // winc is a request qualified by wfull; a write happens exactly when wen=1.
    logic                 winc;
    logic                 wfull;
    logic [PTR_WIDTH-1:0] wq2_rptr;
    logic                 wclr_ovf;

    logic                 wen;
    logic [PTR_WIDTH-2:0] waddr;
    logic [PTR_WIDTH-1:0] wgray_nxt;
    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] wlevel;
    logic                 walmost_full;
    logic                 woverflow;

    modport master (
        output winc, wfull, wq2_rptr, wclr_ovf,
        input  wen, waddr, wgray_nxt, wptr, wlevel, walmost_full, woverflow
    );

    modport slave (
        input  winc, wfull, wq2_rptr, wclr_ovf,
        output wen, waddr, wgray_nxt, wptr, wlevel, walmost_full, woverflow
    );

endinterface

// File: rtl/wptr_ctrl_gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all
// gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/wptr_ctrl.sv
// Write-domain pointer controller for an async FIFO: binary/gray write pointer,
// pessimistic fill level, almost-full and sticky overflow flags.
module wptr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int PTR_WIDTH    = PTR_WIDTH_DEF,
    parameter int AFULL_THRESH = (2 ** (PTR_WIDTH - 1)) - 2
) (
    input  logic       wclk,
    input  logic       wrst_n,
    wptr_ctrl_if.slave wif
);

    localparam logic [PTR_WIDTH-1:0] AFULL_T = PTR_WIDTH'(AFULL_THRESH);

    logic                 wen_s;
    logic [PTR_WIDTH-1:0] rbin_s;
    logic [PTR_WIDTH-1:0] wbin_q,   wbin_d;
    logic [PTR_WIDTH-1:0] wptr_q,   wgray_d;
    logic [PTR_WIDTH-1:0] wlevel_q, wlevel_d;
    logic                 afull_q,  afull_d;
    logic                 ovf_q,    ovf_d;

    gray2bin #(
        .WIDTH (PTR_WIDTH)
    ) u_rptr_g2b (
        .gray_i (wif.wq2_rptr),
        .bin_o  (rbin_s)
    );

    always_comb begin
        wen_s    = wif.winc & ~wif.wfull;
        wbin_d   = wbin_q + {{(PTR_WIDTH-1){1'b0}}, wen_s};
        wgray_d  = PTR_WIDTH'(bin2gray(32'(wbin_d)));
        // Subtraction wraps naturally; the extra pointer MSB keeps 0..DEPTH distinct.
        wlevel_d = wbin_d - rbin_s;
        afull_d  = (wlevel_d >= AFULL_T);
        if (wif.winc && wif.wfull) begin
            ovf_d = 1'b1;
        end else if (wif.wclr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wgray_d;
            wlevel_q <= wlevel_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    // wptr crosses clock domains, so it comes straight from a flop.
    assign wif.wen          = wen_s;
    assign wif.waddr        = wbin_q[PTR_WIDTH-2:0];
    assign wif.wgray_nxt    = wgray_d;
    assign wif.wptr         = wptr_q;
    assign wif.wlevel       = wlevel_q;
    assign wif.walmost_full = afull_q;
    assign wif.woverflow    = ovf_q;

endmodule

// File: tb/tb_wptr_ctrl.sv
// Self-checking bench for wptr_ctrl with PTR_WIDTH=4, AFULL_THRESH=6 and a
// registered full-flag stage modelled alongside the DUT.
module tb_wptr_ctrl;
  import async_fifo_pkg::*;

  localparam int PW = 4;
  localparam int AF = 6;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  logic [PW-1:0] prev_wptr = '0;

  logic [9:0] exp_q[$];

  wptr_ctrl_if #(.PTR_WIDTH(PW)) wif ();

  wptr_ctrl #(
    .PTR_WIDTH    (PW),
    .AFULL_THRESH (AF)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wif    (wif)
  );

  // clock / reset
  always #5 wclk = ~wclk;

  // downstream full-flag stage: full when next write pointer equals read pointer
  // with its two MSBs inverted
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) wif.wfull <= 1'b0;
    else wif.wfull <= (wif.wgray_nxt == {~wif.wq2_rptr[PW-1:PW-2], wif.wq2_rptr[PW-3:0]});
  end

  typedef struct {
    logic          winc;
    logic          clr;
    logic [PW-1:0] rptr;
    logic          exp_wen;
    logic [PW-2:0] exp_addr;
    logic [PW-1:0] exp_wptr;
    logic [PW-1:0] exp_lvl;
    logic          exp_af;
    logic          exp_ovf;
    logic          exp_full;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mkv(input logic winc, input logic clr, input logic [PW-1:0] rptr,
                               input logic wen, input logic [PW-2:0] addr,
                               input logic [PW-1:0] wptr, input logic [PW-1:0] lvl,
                               input logic af, input logic ovf, input logic full);
    vec_t v;
    v.winc = winc; v.clr = clr; v.rptr = rptr;
    v.exp_wen = wen; v.exp_addr = addr; v.exp_wptr = wptr; v.exp_lvl = lvl;
    v.exp_af = af; v.exp_ovf = ovf; v.exp_full = full;
    return v;
  endfunction

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // advance one edge and verify the single-bit-change property of wptr
  task automatic tick();
    @(posedge wclk);
    #1;
    if (!wrst_n) begin
      prev_wptr = '0;
    end else begin
      check("wptr_one_bit_step", 32'($countones(prev_wptr ^ wif.wptr) <= 1), 32'd1);
      prev_wptr = wif.wptr;
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge wclk);
    wif.winc = v.winc;
    wif.wclr_ovf = v.clr;
    wif.wq2_rptr = v.rptr;
    #1;
    check($sformatf("v%0d_wen", idx), 32'(wif.wen), 32'(v.exp_wen));
    check($sformatf("v%0d_waddr", idx), 32'(wif.waddr), 32'(v.exp_addr));
    tick();
    check($sformatf("v%0d_wptr", idx), 32'(wif.wptr), 32'(v.exp_wptr));
    check($sformatf("v%0d_wlevel", idx), 32'(wif.wlevel), 32'(v.exp_lvl));
    check($sformatf("v%0d_afull", idx), 32'(wif.walmost_full), 32'(v.exp_af));
    check($sformatf("v%0d_ovf", idx), 32'(wif.woverflow), 32'(v.exp_ovf));
    check($sformatf("v%0d_wfull", idx), 32'(wif.wfull), 32'(v.exp_full));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wptr"}, 32'(wif.wptr), 32'd0);
    check({tag, "_wlevel"}, 32'(wif.wlevel), 32'd0);
    check({tag, "_afull"}, 32'(wif.walmost_full), 32'd0);
    check({tag, "_ovf"}, 32'(wif.woverflow), 32'd0);
    check({tag, "_waddr"}, 32'(wif.waddr), 32'd0);
  endtask

  initial begin
    logic [PW-1:0] m_bin;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] lag;
    logic [PW-1:0] lvl;
    logic [9:0]    exp_v;

    //          winc  clr   rptr     wen   addr  wptr     lvl    af    ovf   full
    vecs[0]  = mkv(1'b1, 1'b0, 4'b0000, 1'b1, 3'd0, 4'b0001, 4'd1, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mkv(1'b1, 1'b0, 4'b0000, 1'b1, 3'd1, 4'b0011, 4'd2, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mkv(1'b1, 1'b0, 4'b0000, 1'b1, 3'd2, 4'b0010, 4'd3, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mkv(1'b1, 1'b0, 4'b0000, 1'b1, 3'd3, 4'b0110, 4'd4, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mkv(1'b1, 1'b0, 4'b0000, 1'b1, 3'd4, 4'b0111, 4'd5, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mkv(1'b1, 1'b0, 4'b0000, 1'b1, 3'd5, 4'b0101, 4'd6, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mkv(1'b1, 1'b0, 4'b0000, 1'b1, 3'd6, 4'b0100, 4'd7, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mkv(1'b1, 1'b0, 4'b0000, 1'b1, 3'd7, 4'b1100, 4'd8, 1'b1, 1'b0, 1'b1);
    vecs[8]  = mkv(1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b1);
    vecs[9]  = mkv(1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 4'd8, 1'b1, 1'b0, 1'b1);
    vecs[10] = mkv(1'b1, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b1);
    vecs[11] = mkv(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b1);
    vecs[12] = mkv(1'b0, 1'b0, 4'b1100, 1'b0, 3'd0, 4'b1100, 4'd0, 1'b0, 1'b1, 1'b0);

    wif.winc = 1'b0;
    wif.wclr_ovf = 1'b0;
    wif.wq2_rptr = '0;

    // reset state, before any clock edge
    #1;
    check_all_zero("reset");
    check("reset_wen", 32'(wif.wen), 32'd0);
    tick();
    tick();
    @(negedge wclk);
    wrst_n = 1'b1;

    // directed fill / full / overflow / clear sequence
    for (int i = 0; i < 13; i++) apply_vec(vecs[i], i);

    // wrap with a read pointer trailing the writes
    m_bin = 4'd8;
    r_bin = 4'd8;
    for (int i = 0; i < 20; i++) begin
      @(negedge wclk);
      lag = m_bin - r_bin;
      if (lag >= 4'd3) r_bin = r_bin + 4'd1;
      else if (lag != 4'd0 && $urandom_range(0, 1) == 1) r_bin = r_bin + 4'd1;
      wif.wq2_rptr = to_gray(r_bin);
      wif.winc = 1'b1;
      wif.wclr_ovf = 1'b0;
      #1;
      check("wrap_wen", 32'(wif.wen), 32'd1);
      check("wrap_waddr", 32'(wif.waddr), 32'(m_bin[PW-2:0]));
      check("wrap_wgray_nxt", 32'(wif.wgray_nxt), 32'(to_gray(m_bin + 4'd1)));
      lvl = m_bin + 4'd1 - r_bin;
      exp_q.push_back({to_gray(m_bin + 4'd1), lvl, (lvl >= 4'(AF)), 1'b1});
      m_bin = m_bin + 4'd1;
      tick();
      exp_v = exp_q.pop_front();
      check("wrap_regs", 32'({wif.wptr, wif.wlevel, wif.walmost_full, wif.woverflow}), 32'(exp_v));
      check("wrap_wfull", 32'(wif.wfull), 32'd0);
    end

    // reset mid-burst at wbin=5
    @(negedge wclk);
    wif.winc = 1'b0;
    wif.wq2_rptr = '0;
    wrst_n = 1'b0;
    tick();
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      wif.winc = 1'b1;
      tick();
    end
    @(negedge wclk);
    check("pre_rst_wptr", 32'(wif.wptr), 32'(4'b0111));
    check("pre_rst_waddr", 32'(wif.waddr), 32'd5);
    #2;
    wrst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("async_rst_wen", 32'(wif.wen), 32'd1);
    check("async_rst_wgray_nxt", 32'(wif.wgray_nxt), 32'(4'b0001));
    tick();
    @(negedge wclk);
    wrst_n = 1'b1;
    #1;
    check("resume_waddr", 32'(wif.waddr), 32'd0);
    check("resume_wen", 32'(wif.wen), 32'd1);
    tick();
    check("resume_wptr", 32'(wif.wptr), 32'(4'b0001));
    check("resume_wlevel", 32'(wif.wlevel), 32'd1);
    @(negedge wclk);
    wif.winc = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
